// File: rtl/ksa_swap_fsm_if.sv
// rtl/ksa_swap_fsm_if.sv - S-memory port shared by the key-scheduling FSM and the S RAM
interface ksa_swap_fsm_if;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;

  modport master (
    output ram_addr,
    output ram_wdata,
    output ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_wdata,
    input  ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/ksa_swap_fsm.sv
// rtl/ksa_swap_fsm.sv - RC4 key scheduling over a 256-byte S memory, one swap per 6 cycles
module ksa_swap_fsm #(
  parameter int KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  ksa_swap_fsm_if.master       ram,
  output logic                 busy,
  output logic                 fin_strobe
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_I = 3'd1,
    LD_I = 3'd2,
    RD_J = 3'd3,
    LD_J = 3'd4,
    WR_I = 3'd5,
    WR_J = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t               state;
  logic [8*KEY_LEN-1:0] key_q;
  logic [7:0]           i;
  logic [7:0]           j;
  logic [2:0]           k;
  logic [7:0]           si;
  logic [7:0]           sj;
  logic [7:0]           key_byte;
  logic [7:0]           j_next;

  // key byte 0 sits in the most-significant byte of the latched key
  always_comb begin
    key_byte = key_q[8*(KEY_LEN-1-int'(k)) +: 8];
    j_next   = j + ram.ram_rdata + key_byte;
  end

  // Outputs are registered: each transition loads the bus values of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      key_q         <= '0;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      si            <= '0;
      sj            <= '0;
      ram.ram_addr  <= '0;
      ram.ram_wdata <= '0;
      ram.ram_we    <= 1'b0;
      busy          <= 1'b0;
      fin_strobe    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fin_strobe <= 1'b0;
          if (start) begin
            key_q        <= secret_key;
            i            <= '0;
            j            <= '0;
            k            <= '0;
            ram.ram_addr <= '0;
            ram.ram_we   <= 1'b0;
            busy         <= 1'b1;
            state        <= RD_I;
          end
        end
        RD_I: state <= LD_I;
        LD_I: begin
          si           <= ram.ram_rdata;
          j            <= j_next;
          ram.ram_addr <= j_next;
          state        <= RD_J;
        end
        RD_J: state <= LD_J;
        LD_J: begin
          sj            <= ram.ram_rdata;
          ram.ram_addr  <= i;
          ram.ram_wdata <= ram.ram_rdata;
          ram.ram_we    <= 1'b1;
          state         <= WR_I;
        end
        WR_I: begin
          ram.ram_addr  <= j;
          ram.ram_wdata <= si;
          state         <= WR_J;
        end
        WR_J: begin
          ram.ram_we <= 1'b0;
          if (i == 8'd255) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            i            <= i + 8'd1;
            k            <= (k == 3'(KEY_LEN-1)) ? 3'd0 : k + 3'd1;
            ram.ram_addr <= i + 8'd1;
            state        <= RD_I;
          end
        end
        DONE: begin
          fin_strobe <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          ram.ram_we <= 1'b0;
          busy       <= 1'b0;
          fin_strobe <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb/tb_ksa_swap_fsm.sv - scoreboard bench for ksa_swap_fsm with KEY_LEN 3 and KEY_LEN 1 instances
module tb_ksa_swap_fsm;
  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start1;
  logic [23:0] key3;
  logic [7:0]  key1;
  logic        busy3, fin3, busy1, fin1;
  logic        init_mem;

  always #5 clk = ~clk;

  ksa_swap_fsm_if bus3 ();
  ksa_swap_fsm_if bus1 ();

  ksa_swap_fsm #(.KEY_LEN(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .secret_key(key3),
    .ram(bus3.master), .busy(busy3), .fin_strobe(fin3)
  );

  ksa_swap_fsm #(.KEY_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .secret_key(key1),
    .ram(bus1.master), .busy(busy1), .fin_strobe(fin1)
  );

  logic [7:0]  mem [2][256];
  logic [7:0]  sm  [2][256];
  logic [15:0] q3 [$];
  logic [15:0] q1 [$];
  int          checks = 0;
  int          errors = 0;
  int          fin_cnt3 = 0;
  int          fin_cnt1 = 0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int n = 0; n < 256; n++) begin
        mem[0][n] <= 8'(n);
        mem[1][n] <= 8'(n);
      end
    end else begin
      if (bus3.ram_we) mem[0][bus3.ram_addr] <= bus3.ram_wdata;
      if (bus1.ram_we) mem[1][bus1.ram_addr] <= bus1.ram_wdata;
    end
    bus3.ram_rdata <= mem[0][bus3.ram_addr];
    bus1.ram_rdata <= mem[1][bus1.ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // every write must be the next one the model predicted; an unpredicted write always mismatches
  always @(negedge clk) begin
    logic [15:0] obs, exp;
    if (bus3.ram_we) begin
      obs = {bus3.ram_addr, bus3.ram_wdata};
      exp = (q3.size() != 0) ? q3.pop_front() : ~obs;
      check_val("wr3", 32'(obs), 32'(exp));
    end
    if (bus1.ram_we) begin
      obs = {bus1.ram_addr, bus1.ram_wdata};
      exp = (q1.size() != 0) ? q1.pop_front() : ~obs;
      check_val("wr1", 32'(obs), 32'(exp));
    end
    if (fin3) fin_cnt3++;
    if (fin1) fin_cnt1++;
  end

  task automatic reload_mem();
    @(negedge clk);
    init_mem = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int n = 0; n < 256; n++) sm[s][n] = 8'(n);
    @(negedge clk);
    init_mem = 1'b0;
  endtask

  task automatic model_run(input int sel, input logic [63:0] key, input int klen);
    logic [7:0] j, kb, t;
    logic [15:0] e0, e1;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(klen-1-(i % klen)) +: 8];
      j  = j + sm[sel][i] + kb;
      e0 = {8'(i), sm[sel][j]};
      e1 = {j, sm[sel][i]};
      if (sel == 0) begin q3.push_back(e0); q3.push_back(e1); end
      else          begin q1.push_back(e0); q1.push_back(e1); end
      t = sm[sel][i];
      sm[sel][i] = sm[sel][j];
      sm[sel][j] = t;
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start3 = v;
    else          start1 = v;
  endtask

  task automatic accept(input int sel, input string tag);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    check_val({tag, "_busy_on_accept"}, 32'((sel == 0) ? busy3 : busy1), 32'd1);
  endtask

  task automatic wait_fin(input int sel, input string tag);
    int cyc;
    int f0;
    cyc = 0;
    f0  = (sel == 0) ? fin_cnt3 : fin_cnt1;
    while (cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (((sel == 0) ? fin3 : fin1) == 1'b1) break;
    end
    check_val({tag, "_latency"}, 32'(cyc), 32'd1537);
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_fin_once"}, 32'(((sel == 0) ? fin_cnt3 : fin_cnt1) - f0), 32'd1);
  endtask

  task automatic check_mem(input int sel, input string tag);
    int bad;
    bad = 0;
    for (int n = 0; n < 256; n++) if (mem[sel][n] !== sm[sel][n]) bad++;
    check_val({tag, "_mem_bad_bytes"}, 32'(bad), 32'd0);
    check_val({tag, "_writes_left"}, 32'((sel == 0) ? q3.size() : q1.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start3 = 1'b0; start1 = 1'b0; key3 = '0; key1 = '0; init_mem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy3", 32'(busy3), 32'd0);
    check_val("rst_fin3", 32'(fin3), 32'd0);
    check_val("rst_we3", 32'(bus3.ram_we), 32'd0);
    check_val("rst_addr3", 32'(bus3.ram_addr), 32'd0);
    check_val("rst_wdata3", 32'(bus3.ram_wdata), 32'd0);
    check_val("rst_busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // all-zero key: i=0 self-swap at addr 0, i=2 swaps addresses 2 and 3
    reload_mem();
    key3 = 24'h000000;
    model_run(0, 64'h0, 3);
    accept(0, "zero_key");
    start3 = 1'b0;
    wait_fin(0, "zero_key");
    check_mem(0, "zero_key");

    // key replaced right after latching must not disturb the run
    reload_mem();
    key3 = 24'h0103C0;
    model_run(0, 64'h0103C0, 3);
    accept(0, "key_0103c0");
    start3 = 1'b0;
    key3 = 24'hA5F00F;
    wait_fin(0, "key_0103c0");
    check_mem(0, "key_0103c0");

    // start held high: exactly two back-to-back runs, second over the first run's result
    reload_mem();
    key3 = 24'h0103C0;
    model_run(0, 64'h0103C0, 3);
    model_run(0, 64'h0103C0, 3);
    accept(0, "held_a");
    wait_fin(0, "held_a");
    check_val("held_restart_busy", 32'(busy3), 32'd1);
    start3 = 1'b0;
    wait_fin(0, "held_b");
    check_mem(0, "held");

    // reset during LD_J of i=100, then a clean restart
    reload_mem();
    key3 = 24'h123456;
    model_run(0, 64'h123456, 3);
    accept(0, "abort");
    start3 = 1'b0;
    repeat (603) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort_we", 32'(bus3.ram_we), 32'd0);
    check_val("abort_busy", 32'(busy3), 32'd0);
    q3.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reload_mem();
    model_run(0, 64'h123456, 3);
    accept(0, "restart");
    start3 = 1'b0;
    wait_fin(0, "restart");
    check_mem(0, "restart");

    // single-byte key 0xFF: j wraps to 0xFF at i=0, so S[0] and S[255] swap first
    reload_mem();
    key1 = 8'hFF;
    model_run(1, 64'hFF, 1);
    accept(1, "klen1");
    start1 = 1'b0;
    wait_fin(1, "klen1");
    check_mem(1, "klen1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
